// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_QUEUES header-tagged packet streams onto one
// output, holding the grant for a whole packet and advancing the fairness pointer at end-of-packet.
module pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 4,
    localparam int SRC_W     = (NUM_QUEUES > 2) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] i_in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] i_in_ctrl,
    input  logic [NUM_QUEUES-1:0]            i_in_wr,
    input  logic [NUM_QUEUES-1:0]            i_in_req,
    output logic [NUM_QUEUES-1:0]            o_in_rdy,
    output logic [DATA_WIDTH-1:0]            o_out_data,
    output logic [CTRL_WIDTH-1:0]            o_out_ctrl,
    output logic                             o_out_wr,
    input  logic                             i_out_rdy,
    output logic [SRC_W-1:0]                 o_out_src
);

    // IDLE: arbitrate among requesters | HDR: module-header words | BODY: body words until ctrl != 0
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    logic [1:0]       r_state;
    logic [SRC_W-1:0] r_grant;
    logic [SRC_W-1:0] r_rr_ptr;

    logic [DATA_WIDTH-1:0]   w_data_arr [NUM_QUEUES];
    logic [CTRL_WIDTH-1:0]   w_ctrl_arr [NUM_QUEUES];
    logic [2*NUM_QUEUES-1:0] w_req_dbl;
    logic [NUM_QUEUES-1:0]   w_req_rot;
    logic [SRC_W-1:0]        w_off;
    logic                    w_any_req;
    logic [SRC_W:0]          w_sum;
    logic [SRC_W-1:0]        w_next_grant;
    logic [SRC_W-1:0]        w_ptr_next;
    logic                    w_active;
    logic                    w_ctrl_nz;

    genvar g;
    generate
        for (g = 0; g < NUM_QUEUES; g++) begin : g_unpack
            assign w_data_arr[g] = i_in_data[g*DATA_WIDTH +: DATA_WIDTH];
            assign w_ctrl_arr[g] = i_in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH];
        end
    endgenerate

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next grant offset.
    assign w_req_dbl = {i_in_req, i_in_req};
    assign w_req_rot = NUM_QUEUES'(w_req_dbl >> r_rr_ptr);

    always_comb begin
        w_off     = '0;
        w_any_req = 1'b0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off     = SRC_W'(i);
                w_any_req = 1'b1;
            end
        end
    end

    assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_next_grant = (w_sum >= (SRC_W+1)'(NUM_QUEUES))
                          ? SRC_W'(w_sum - (SRC_W+1)'(NUM_QUEUES)) : SRC_W'(w_sum);
    assign w_ptr_next   = (r_grant == SRC_W'(NUM_QUEUES - 1)) ? '0 : r_grant + 1'b1;

    assign w_active   = (r_state != ST_IDLE);
    assign o_out_data = w_data_arr[r_grant];
    assign o_out_ctrl = w_ctrl_arr[r_grant];
    assign o_out_wr   = w_active && i_in_wr[r_grant] && i_out_rdy;
    assign o_out_src  = r_grant;
    assign w_ctrl_nz  = |o_out_ctrl;

    always_comb begin
        o_in_rdy          = '0;
        o_in_rdy[r_grant] = w_active && i_out_rdy;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_next_grant;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (o_out_wr && !w_ctrl_nz) r_state <= ST_BODY;
                end
                ST_BODY: begin
                    if (o_out_wr && w_ctrl_nz) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter with 4 queues of 64-bit words.
module tb_pkt_rr_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0]   in_wr;
    logic [NQ-1:0]   in_req;
    logic [NQ-1:0]   in_rdy;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ctrl;
    logic            out_wr;
    logic            out_rdy;
    logic [1:0]      out_src;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pkt_rr_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_in_data  (in_data),
        .i_in_ctrl  (in_ctrl),
        .i_in_wr    (in_wr),
        .i_in_req   (in_req),
        .o_in_rdy   (in_rdy),
        .o_out_data (out_data),
        .o_out_ctrl (out_ctrl),
        .o_out_wr   (out_wr),
        .i_out_rdy  (out_rdy),
        .o_out_src  (out_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int q, input logic [63:0] d, input logic [7:0] c, input logic w);
        in_data[q*DW +: DW] = d;
        in_ctrl[q*CW +: CW] = c;
        in_wr[q]            = w;
    endtask

    // Present one word on input q, check the 0-latency pass-through, then clock it in.
    task automatic xfer(input int q, input logic [63:0] d, input logic [7:0] c, input string tag);
        put(q, d, c, 1'b1);
        #1;
        chk({tag, "_wr"},   64'(out_wr),   64'd1);
        chk({tag, "_data"}, out_data,      d);
        chk({tag, "_ctrl"}, 64'(out_ctrl), 64'(c));
        chk({tag, "_rdy"},  64'(in_rdy),   64'(4'b0001 << q));
        cyc();
        in_wr[q] = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        int q;
        reset   = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = '0;
        in_req  = '0;
        out_rdy = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        #1;
        chk("rst_rdy", 64'(in_rdy),  64'd0);
        chk("rst_wr",  64'(out_wr),  64'd0);
        chk("rst_src", 64'(out_src), 64'd0);

        // single requester on input 2
        in_req = 4'b0100;
        put(2, 64'hA0, 8'hff, 1'b1);
        #1;
        chk("a_idle_wr",  64'(out_wr), 64'd0);
        chk("a_idle_rdy", 64'(in_rdy), 64'd0);
        cyc();
        chk("a_src", 64'(out_src), 64'd2);
        in_req = 4'b0000;
        xfer(2, 64'hA0, 8'hff, "a_h");
        xfer(2, 64'hA1, 8'h00, "a_b1");
        xfer(2, 64'hA2, 8'h00, "a_b2");
        xfer(2, 64'hA3, 8'h00, "a_b3");
        xfer(2, 64'hA4, 8'h04, "a_last");
        chk("a_end_rdy", 64'(in_rdy), 64'd0);
        chk("a_end_wr",  64'(out_wr), 64'd0);
        in_req = 4'b1001;
        cyc();
        chk("a_ptr3", 64'(out_src), 64'd3);
        in_req = 4'b0000;
        reset  = 1'b1;
        cyc();
        reset = 1'b0;

        // all inputs requesting, all inputs writing: order 0,1,2,3,0 with one bubble each
        in_req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            q = p % NQ;
            for (int j = 0; j < NQ; j++) put(j, 64'hB000 + 64'(j), 8'hff, 1'b1);
            #1;
            chk("b_bubble_rdy", 64'(in_rdy), 64'd0);
            chk("b_bubble_wr",  64'(out_wr), 64'd0);
            cyc();
            chk("b_src", 64'(out_src), 64'(q));
            for (int k = 0; k < 4; k++) begin
                c = (k == 0) ? 8'hff : ((k == 3) ? 8'h01 : 8'h00);
                for (int j = 0; j < NQ; j++)
                    put(j, 64'hB000 + 64'(p << 8) + 64'(j << 4) + 64'(k), c, 1'b1);
                #1;
                chk("b_data", out_data, 64'hB000 + 64'(p << 8) + 64'(q << 4) + 64'(k));
                chk("b_wr",   64'(out_wr), 64'd1);
                chk("b_rdy",  64'(in_rdy), 64'(4'b0001 << q));
                cyc();
            end
        end
        in_req = 4'b0000;
        in_wr  = 4'b0000;

        // stall mid-body on input 1 (rr_ptr now 1)
        in_req = 4'b0010;
        cyc();
        chk("c_src", 64'(out_src), 64'd1);
        in_req = 4'b0000;
        xfer(1, 64'hC0, 8'hff, "c_h");
        xfer(1, 64'hC1, 8'h00, "c_b1");
        out_rdy = 1'b0;
        put(1, 64'hC2, 8'h00, 1'b1);
        repeat (3) begin
            #1;
            chk("c_stall_rdy", 64'(in_rdy),  64'd0);
            chk("c_stall_wr",  64'(out_wr),  64'd0);
            chk("c_stall_src", 64'(out_src), 64'd1);
            cyc();
        end
        out_rdy = 1'b1;
        xfer(1, 64'hC2, 8'h00, "c_b2");
        xfer(1, 64'hC3, 8'h80, "c_last");
        chk("c_end_rdy", 64'(in_rdy), 64'd0);

        // input 0 alone with rr_ptr at 2; input 1 writes are ignored
        in_req = 4'b0001;
        cyc();
        chk("d_src", 64'(out_src), 64'd0);
        in_req = 4'b0000;
        put(1, 64'hEEEE, 8'h00, 1'b1);
        xfer(0, 64'hD0, 8'hff, "d_h");
        in_wr[1] = 1'b0;
        xfer(0, 64'hD1, 8'h00, "d_b1");
        put(1, 64'hEEEF, 8'h01, 1'b1);
        xfer(0, 64'hD2, 8'h00, "d_b2");
        xfer(0, 64'hD3, 8'h02, "d_last");
        in_wr[1] = 1'b0;
        chk("d_end_rdy", 64'(in_rdy), 64'd0);

        // two header words before the body on input 1 (rr_ptr now 1)
        in_req = 4'b0010;
        cyc();
        chk("e_src", 64'(out_src), 64'd1);
        in_req = 4'b0000;
        xfer(1, 64'hE0, 8'hff, "e_h1");
        xfer(1, 64'hE1, 8'hff, "e_h2");
        xfer(1, 64'hE2, 8'h00, "e_b1");
        xfer(1, 64'hE3, 8'h00, "e_b2");
        xfer(1, 64'hE4, 8'h01, "e_last");
        chk("e_end_rdy", 64'(in_rdy), 64'd0);

        // reset in the middle of input 3's body (rr_ptr now 2)
        in_req = 4'b1000;
        cyc();
        chk("f_src", 64'(out_src), 64'd3);
        in_req = 4'b0000;
        xfer(3, 64'hF0, 8'hff, "f_h");
        xfer(3, 64'hF1, 8'h00, "f_b1");
        put(3, 64'hF2, 8'h00, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("f_rst_rdy", 64'(in_rdy),  64'd0);
        chk("f_rst_wr",  64'(out_wr),  64'd0);
        chk("f_rst_src", 64'(out_src), 64'd0);
        in_wr  = 4'b0000;
        in_req = 4'b1010;
        cyc();
        chk("f_ptr0", 64'(out_src), 64'd1);
        in_req = 4'b0000;
        xfer(1, 64'h90, 8'hff, "f1_h");
        xfer(1, 64'h91, 8'h00, "f1_b");
        xfer(1, 64'h92, 8'h01, "f1_last");
        in_req = 4'b1000;
        #1;
        chk("f_idle_rdy", 64'(in_rdy), 64'd0);
        cyc();
        chk("f_src3", 64'(out_src), 64'd3);
        chk("f_rdy3", 64'(in_rdy),  64'b1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pkt_rr_arbiter.md
# pkt_rr_arbiter

Packet-granular round-robin arbiter that merges NUM_QUEUES header-tagged packet streams onto one output stream in the IO-queue word format. It sits downstream of the per-port length-header inserters and upstream of the output-port lookup stage. It grants one input at a time for a whole packet and advances a fairness pointer only at end-of-packet. The datapath is a combinational mux; grant and state are registered.

## Interface
Parameters:
- DATA_WIDTH, 64, data word width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width (one bit per data byte)
- NUM_QUEUES, 4, number of input streams (2..8)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_data  in  NUM_QUEUES*DATA_WIDTH  input i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  packed the same way
- in_wr  in  NUM_QUEUES  per-input word valid
- in_req  in  NUM_QUEUES  per-input "at least one complete packet pending"
- in_rdy  out  NUM_QUEUES  per-input accept
- out_data  out  DATA_WIDTH  merged data
- out_ctrl  out  CTRL_WIDTH  merged ctrl
- out_wr  out  1  merged word valid
- out_rdy  in  1  downstream can accept a word this cycle
- out_src  out  log2(NUM_QUEUES) (min 1)  index of current grant

## Operation
- Packet format: one or more module-header words (ctrl != 0), then body words (ctrl == 0), ending with one word with ctrl != 0 (last-word byte marker). Header-only packets are not supported.
- States: IDLE, HDR, BODY. Registers: state, grant, rr_ptr.
- IDLE: all in_rdy = 0 and out_wr = 0. If any in_req bit is set, grant <= the first requesting index searched from rr_ptr upward, modulo NUM_QUEUES, and the state moves to HDR. Otherwise the state stays in IDLE.
- HDR and BODY: in_rdy[grant] = out_rdy and all other in_rdy = 0. out_wr = in_wr[grant] && out_rdy. out_data and out_ctrl are driven by the granted slice.
- HDR: a word accepted with ctrl == 0 moves the state to BODY. A word with ctrl != 0 keeps the state in HDR.
- BODY: a word accepted with ctrl != 0 is end-of-packet. On that word the state returns to IDLE and rr_ptr <= (grant+1) mod NUM_QUEUES.
- in_wr on a non-granted input is ignored and is never forwarded.
- in_req is sampled only in IDLE. Changes to in_req mid-packet have no effect.
- out_src = grant at all times.
- In IDLE, out_data and out_ctrl still mux the slice selected by grant (don't-care, no out_wr).

## Timing
- Reset values: state = IDLE, grant = 0, rr_ptr = 0. Hence in_rdy = 0, out_wr = 0, out_src = 0. Reset overrides everything in the same cycle, including mid-packet; a partial packet is abandoned and the upstream resynchronizes.
- Latency: 0 cycles from in_wr[grant] to out_wr (combinational pass-through).
- Arbitration: 1 IDLE cycle per packet. Back-to-back packets therefore have exactly one bubble between them.
- out_rdy low stalls the transfer: in_rdy[grant] = 0 and the state and grant hold.
- Fairness: with all inputs requesting, the service order is rr_ptr, rr_ptr+1, … with wrap-around. No input waits more than NUM_QUEUES-1 packets.
- rr_ptr wraps from NUM_QUEUES-1 to 0.
- A single requester is regranted every packet regardless of rr_ptr.

## Test plan
- Single input 2 requests a packet of 1 header + 3 body + last word (ctrl = 0x04) -> grant = 2 one cycle after in_req; 5 words appear on out_* with 0-cycle latency; IDLE after the last word; rr_ptr = 3.
- All 4 inputs request continuously, one 4-word packet each, from reset -> service order 0,1,2,3,0; exactly one idle cycle between packets; no interleaved words.
- out_rdy deasserted for 3 cycles mid-body -> in_rdy[grant] = 0 and out_wr = 0 for those cycles; the word stream resumes intact; grant is unchanged.
- in_wr pulsed on non-granted input 1 during a packet from input 0 -> out_* carries only input 0 words; in_rdy[1] stays 0.
- Packet with 2 header words (ctrl = 0xff) then body -> the state stays HDR through both header words and enters BODY on the first ctrl == 0 word; end-of-packet is detected only on the later ctrl != 0 word.
- reset asserted mid-body of input 3's packet -> next cycle state = IDLE, grant = 0, rr_ptr = 0, all in_rdy = 0; a subsequent request on input 3 is granted after 1 IDLE cycle.
